// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiply controller for the EX stage.
// Stalls the pipeline for WIDTH+1 cycles, then presents the low WIDTH bits of the product for one cycle.
module mul_sequencer #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [2:0]  MUL_CODE = 3'b100
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             accept;

    assign accept = (state_q == IDLE) && start_i && (ALUCtrl_i == MUL_CODE) && !flush_i;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    result_d = '0;
                end else if (accept) begin
                    mcand_d  = data1_i;
                    mplier_d = data2_i;
                    acc_d    = '0;
                    count_d  = '0;
                    result_d = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    mcand_d  = '0;
                    mplier_d = '0;
                    acc_d    = '0;
                    count_d  = '0;
                    result_d = '0;
                    state_d  = IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                    // Capture the final sum on the way out so result_o is valid throughout DONE.
                    if (count_q == CW'(WIDTH - 1)) begin
                        result_d = acc_d;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // Gate with reset so a held MUL request cannot raise stall while reset is asserted.
    assign stall_o  = rst_i && (accept || (state_q == BUSY));
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer.
module tb_mul_sequencer;

    localparam logic [2:0] MUL = 3'b100;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;

    mul_sequencer #(.WIDTH(32), .MUL_CODE(3'b100)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .start_i   (start),
        .ALUCtrl_i (ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .flush_i   (flush),
        .stall_o   (stall),
        .done_o    (done),
        .result_o  (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts consecutive stalled cycles starting from the current one, bounded.
    task automatic count_stalls(input int start_n, output int n);
        n = start_n;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int n;
        @(negedge clk);
        start = 1'b1;
        ctrl  = MUL;
        d1    = a;
        d2    = b;
        #1;
        count_stalls(0, n);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL %s stall_len: got %0d expected 33", name, n);
        end
        checks++;
        if (done !== 1'b1 || result !== exp) begin
            errors++;
            $display("FAIL %s done_result: done=%b result=%h expected done=1 result=%h", name, done, result, exp);
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL %s after_done: stall=%b done=%b result=%h expected 0 0 %h", name, stall, done, result, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        ctrl  = MUL;
        d1    = 32'd3;
        d2    = 32'd5;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: stall=%b done=%b result=%h expected 0 0 0", stall, done, result);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: stall=%b done=%b expected 0 0", stall, done);
        end
    endtask

    task automatic test_basic();
        do_mul(32'd3, 32'd5, 32'd15, "basic_3x5");
    endtask

    task automatic test_wrap();
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "wrap_ffff");
        do_mul(32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, "signed_m3x7");
    endtask

    task automatic test_non_mul();
        int bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1;
        ctrl  = 3'b001;
        d1    = 32'd9;
        d2    = 32'd9;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (stall !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL non_mul cycle %0d: stall=%b done=%b expected 0 0", i, stall, done);
            end
            @(negedge clk);
        end
        start = 1'b0;
        ctrl  = MUL;
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL non_mul_idle: stall=%b done=%b expected 0 0", stall, done);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        start = 1'b1;
        ctrl  = MUL;
        d1    = 32'd3;
        d2    = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: stall=%b expected 1", stall);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL flush_after: stall=%b done=%b result=%h expected 0 0 0", stall, done, result);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_done cycle %0d: done=%b stall=%b expected 0 0", i, done, stall);
            end
        end
        do_mul(32'd6, 32'd7, 32'd42, "post_flush_6x7");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1;
        ctrl  = MUL;
        d1    = 32'd100;
        d2    = 32'd3;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: stall=%b done=%b result=%h expected 0 0 0", stall, done, result);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: stall=%b done=%b expected 0 0", stall, done);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_mul(32'd2, 32'd9, 32'd18, "post_reset_2x9");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start = 1'b1;
        ctrl  = MUL;
        d1    = 32'd4;
        d2    = 32'd4;
        #1;
        count_stalls(0, n);
        checks++;
        if (n !== 33 || done !== 1'b1 || result !== 32'd16) begin
            errors++;
            $display("FAIL b2b_first: stalls=%0d done=%b result=%h expected 33 1 10", n, done, result);
        end
        d1 = 32'd5;
        d2 = 32'd5;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b1 || done !== 1'b0 || result !== 32'd16) begin
            errors++;
            $display("FAIL b2b_accept: stall=%b done=%b result=%h expected 1 0 10", stall, done, result);
        end
        count_stalls(0, n);
        checks++;
        if (n !== 33 || done !== 1'b1 || result !== 32'd25) begin
            errors++;
            $display("FAIL b2b_second: stalls=%0d done=%b result=%h expected 33 1 19", n, done, result);
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd25) begin
            errors++;
            $display("FAIL b2b_end: stall=%b done=%b result=%h expected 0 0 19", stall, done, result);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_non_mul();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
